// File: rtl/fdtd_delay_stream_buf.sv
// ---------------------------------------------------------------------------
// fdtd_delay_stream_buf
//
// Purpose:
//   Elastic, handshaked sample-delay buffer for FDTD field streams. This is
//   the reading end of a delay path. After a run is started with a delay L,
//   the first L accepted samples only prime the buffer. From then on, the
//   block releases sample k in the same cycle that sample k+L is accepted.
//   Input and output move in lockstep, so downstream backpressure stalls the
//   producer instead of losing data. A flush ends the run and drains the
//   samples that are still held, in order.
//
// Ports:
//   CLK          clock
//   RST_N        asynchronous active-low reset
//   start_i      pulse, latches delay_len_i (clamped to 1..MAX_DELAY); only in IDLE
//   delay_len_i  requested delay L
//   flush_i      pulse, ends a PRIME/RUN phase and drains held samples
//   in_valid_i   producer sample valid
//   in_ready_o   block can accept a sample
//   data_i       producer sample
//   out_valid_o  delayed sample valid
//   out_ready_i  consumer ready
//   data_o       delayed sample (oldest held entry)
//   level_o      number of held samples
//   busy_o       high whenever the block is not IDLE
// ---------------------------------------------------------------------------
module fdtd_delay_stream_buf #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int MAX_DELAY       = 16,
  parameter int PTR_W           = $clog2(MAX_DELAY)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start_i,
  input  logic [PTR_W:0]             delay_len_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [FDTD_DATA_WIDTH-1:0] data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [FDTD_DATA_WIDTH-1:0] data_o,
  output logic [PTR_W:0]             level_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [PTR_W:0]   MAX_LEN  = (PTR_W+1)'(MAX_DELAY);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_DELAY - 1);

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [PTR_W:0]       len_q, len_d;

  logic                 wr_en;
  logic                 in_ready;
  logic                 out_valid;

  logic [FDTD_DATA_WIDTH-1:0] mem_rd [MAX_DELAY];

  // Pointers wrap explicitly so MAX_DELAY need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W:0] clamp_len(input logic [PTR_W:0] len);
    if (len == '0) begin
      return CNT_ONE;
    end
    if (len > MAX_LEN) begin
      return MAX_LEN;
    end
    return len;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    len_d     = len_q;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d    = clamp_len(delay_len_i);
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          state_d  = S_PRIME;
        end
      end

      S_PRIME: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + CNT_ONE;
          if ((count_q + CNT_ONE) == len_q) begin
            state_d = S_RUN;
          end
        end
        // A sample accepted in the flush cycle is still kept and drained.
        if (flush_i) begin
          state_d = S_DRAIN;
        end
      end

      S_RUN: begin
        // Lockstep: one in, one out, or nothing at all. The count stays at L.
        in_ready  = out_ready_i;
        out_valid = in_valid_i;
        if (in_valid_i && out_ready_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (flush_i) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        out_valid = (count_q != '0);
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (out_ready_i) begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          count_d  = count_q - CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= CNT_ONE;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      len_q    <= len_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sample storage: one register per entry, cleared by reset so data_o reads
  // zero after reset. The read port is combinational, so in RUN the output
  // sees the old contents while the incoming sample is written at the edge.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_mem
    logic [FDTD_DATA_WIDTH-1:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
        entry_d = data_i;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign mem_rd[gi] = entry_q;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign data_o      = mem_rd[rd_ptr_q];
  assign level_o     = count_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fdtd_delay_stream_buf.sv
// ---------------------------------------------------------------------------
// tb_fdtd_delay_stream_buf
//
// Directed bench for fdtd_delay_stream_buf. Every accepted input is pushed to
// a scoreboard queue. Every output handshake pops the oldest entry and
// compares it with data_o. The held level is compared with the queue depth on
// each cycle. Directed checks cover the handshake outputs in each phase.
// ---------------------------------------------------------------------------
module tb_fdtd_delay_stream_buf;

  localparam int DW    = 32;
  localparam int MAXD  = 16;
  localparam int PTR_W = $clog2(MAXD);

  logic              CLK;
  logic              RST_N;
  logic              start_i;
  logic [PTR_W:0]    delay_len_i;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DW-1:0]     data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DW-1:0]     data_o;
  logic [PTR_W:0]    level_o;
  logic              busy_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] sb[$];

  fdtd_delay_stream_buf #(
    .FDTD_DATA_WIDTH(DW),
    .MAX_DELAY(MAXD)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .start_i(start_i),
    .delay_len_i(delay_len_i),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .data_i(data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .data_o(data_o),
    .level_o(level_o),
    .busy_o(busy_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard update for the handshakes that complete at the next posedge.
  task automatic observe();
    logic [DW-1:0] exp_d;
    chk("level_vs_sb", 32'(level_o), 32'(sb.size()));
    if (in_valid_i && in_ready_o) begin
      sb.push_back(data_i);
    end
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(1), 32'(0));
      end else begin
        exp_d = sb.pop_front();
        chk("sb_data", data_o, exp_d);
      end
    end
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic adv();
    observe();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc();
    neg();
    adv();
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid_i  = iv;
    data_i      = d;
    out_ready_i = ordy;
  endtask

  task automatic start_run(input logic [PTR_W:0] len);
    start_i     = 1'b1;
    delay_len_i = len;
    neg();
    chk("start_idle_in_ready", 32'(in_ready_o), 32'(0));
    adv();
    start_i = 1'b0;
    chk("start_busy", 32'(busy_o), 32'(1));
  endtask

  task automatic wait_idle();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 40 && busy_o === 1'b1; i++) begin
      cyc();
    end
    chk("idle_busy", 32'(busy_o), 32'(0));
    chk("idle_level", 32'(level_o), 32'(0));
    chk("idle_sb_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    RST_N       = 1'b1;
    start_i     = 1'b0;
    delay_len_i = '0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    data_i      = '0;
    out_ready_i = 1'b0;

    // ---- 1. reset -------------------------------------------------------
    #1 RST_N = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'(0));
    chk("rst_out_valid", 32'(out_valid_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_level", 32'(level_o), 32'(0));
    chk("rst_data", data_o, 32'(0));
    @(posedge CLK);
    #1 RST_N = 1'b1;
    cyc();

    // ---- 2. basic delay L=3 ---------------------------------------------
    start_run(3);
    for (int v = 1; v <= 10; v++) begin
      drive(1'b1, DW'(v), 1'b1);
      neg();
      chk("basic_in_ready", 32'(in_ready_o), 32'(1));
      chk("basic_out_valid", 32'(out_valid_o), 32'(v > 3));
      if (v > 3) begin
        chk("basic_data", data_o, 32'(v - 3));
        chk("basic_level", 32'(level_o), 32'(3));
      end
      adv();
    end

    // ---- 4. flush with a mid-drain stall --------------------------------
    drive(1'b0, '0, 1'b1);
    flush_i = 1'b1;
    neg();
    chk("flush_out_valid", 32'(out_valid_o), 32'(0));
    adv();
    flush_i = 1'b0;
    neg();
    chk("drain_in_ready", 32'(in_ready_o), 32'(0));
    chk("drain_data0", data_o, 32'(8));
    adv();
    out_ready_i = 1'b0;
    neg();
    chk("drain_stall_valid", 32'(out_valid_o), 32'(1));
    chk("drain_stall_data", data_o, 32'(9));
    adv();
    out_ready_i = 1'b1;
    neg();
    chk("drain_data1", data_o, 32'(9));
    adv();
    neg();
    chk("drain_data2", data_o, 32'(10));
    adv();
    neg();
    chk("drain_empty_valid", 32'(out_valid_o), 32'(0));
    adv();
    wait_idle();

    // ---- 3. backpressure in RUN -----------------------------------------
    start_run(3);
    for (int v = 21; v <= 25; v++) begin
      drive(1'b1, DW'(v), 1'b1);
      cyc();
    end
    drive(1'b1, DW'(26), 1'b0);
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_in_ready", 32'(in_ready_o), 32'(0));
      chk("bp_level", 32'(level_o), 32'(3));
      chk("bp_data_held", data_o, 32'(23));
      adv();
    end
    out_ready_i = 1'b1;
    neg();
    chk("bp_resume_data", data_o, 32'(23));
    adv();
    drive(1'b1, DW'(27), 1'b1);
    neg();
    chk("bp_next_data", data_o, 32'(24));
    adv();
    drive(1'b0, '0, 1'b1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    wait_idle();

    // ---- 5a. L=0 clamps to 1 --------------------------------------------
    start_run(0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(31 + i), 1'b1);
      neg();
      chk("l0_out_valid", 32'(out_valid_o), 32'(i > 0));
      if (i > 0) begin
        chk("l0_data", data_o, 32'(30 + i));
      end
      adv();
    end
    drive(1'b0, '0, 1'b1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    wait_idle();

    // ---- 5b. L=20 clamps to 16 ------------------------------------------
    start_run(20);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(41 + i), 1'b1);
      neg();
      chk("l20_prime_valid", 32'(out_valid_o), 32'(0));
      adv();
    end
    drive(1'b1, DW'(57), 1'b1);
    neg();
    chk("l20_level", 32'(level_o), 32'(16));
    chk("l20_out_valid", 32'(out_valid_o), 32'(1));
    chk("l20_data", data_o, 32'(41));
    adv();
    drive(1'b0, '0, 1'b1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    wait_idle();

    // ---- 6a. start ignored in RUN, flush coincides with transfer --------
    start_run(2);
    drive(1'b1, DW'(61), 1'b1);
    cyc();
    drive(1'b1, DW'(62), 1'b1);
    cyc();
    drive(1'b1, DW'(63), 1'b1);
    start_i     = 1'b1;
    delay_len_i = 5;
    neg();
    chk("run_start_data", data_o, 32'(61));
    adv();
    start_i = 1'b0;
    drive(1'b1, DW'(64), 1'b1);
    flush_i = 1'b1;
    neg();
    chk("flush_xfer_ready", 32'(in_ready_o), 32'(1));
    chk("flush_xfer_valid", 32'(out_valid_o), 32'(1));
    chk("flush_xfer_data", data_o, 32'(62));
    chk("run_start_level", 32'(level_o), 32'(2));
    adv();
    flush_i = 1'b0;
    drive(1'b0, '0, 1'b1);
    neg();
    chk("flush_xfer_drain_level", 32'(level_o), 32'(2));
    chk("flush_xfer_drain_data", data_o, 32'(63));
    adv();
    wait_idle();

    // ---- 6b. flush during PRIME (2 of 5) --------------------------------
    start_run(5);
    drive(1'b1, DW'(71), 1'b1);
    cyc();
    drive(1'b1, DW'(72), 1'b1);
    cyc();
    drive(1'b0, '0, 1'b1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    neg();
    chk("prime_flush_level", 32'(level_o), 32'(2));
    chk("prime_flush_data", data_o, 32'(71));
    adv();
    wait_idle();

    // ---- 6c. asynchronous reset mid-RUN ---------------------------------
    start_run(3);
    for (int v = 81; v <= 84; v++) begin
      drive(1'b1, DW'(v), 1'b1);
      cyc();
    end
    drive(1'b1, DW'(85), 1'b1);
    #2 RST_N = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy", 32'(busy_o), 32'(0));
    chk("mid_rst_out_valid", 32'(out_valid_o), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready_o), 32'(0));
    chk("mid_rst_level", 32'(level_o), 32'(0));
    chk("mid_rst_data", data_o, 32'(0));
    @(posedge CLK);
    #1 RST_N = 1'b1;
    neg();
    chk("post_rst_out_valid", 32'(out_valid_o), 32'(0));
    chk("post_rst_in_ready", 32'(in_ready_o), 32'(0));
    adv();
    drive(1'b0, '0, 1'b0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
